// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, ctrl bit positions and
// the single-cycle ALU function. Divider selection is controlled by MULDIV_ITER_EN.
package execute_pkg;

    localparam int DIV_CYCLES_DEFAULT = 32;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_MUL = 5'd2,
        ALU_DIV = 5'd3,
        ALU_MOD = 5'd4,
        ALU_CMP = 5'd5,
        ALU_AND = 5'd6,
        ALU_OR  = 5'd7,
        ALU_NOT = 5'd8,
        ALU_MOV = 5'd9,
        ALU_LSL = 5'd10,
        ALU_LSR = 5'd11,
        ALU_ASR = 5'd12
    } alu_op_e;

    // ctrl = {isst,isld,isbeq,isbgt,isret,isimmediate,iswb,isubranch,iscall}
    localparam int CTRL_CALL    = 0;
    localparam int CTRL_UBRANCH = 1;
    localparam int CTRL_WB      = 2;
    localparam int CTRL_IMM     = 3;
    localparam int CTRL_RET     = 4;
    localparam int CTRL_BGT     = 5;
    localparam int CTRL_BEQ     = 6;
    localparam int CTRL_LD      = 7;
    localparam int CTRL_ST      = 8;

    // cmp, div, mod and unassigned codes all produce 0 here; div/mod are
    // overridden by the divider when it is built in.
    function automatic logic [31:0] alu_compute(input logic [4:0]  op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] res;
        res = 32'h0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_MUL: res = a * b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_NOT: res = ~b;
            ALU_MOV: res = b;
            ALU_LSL: res = a << b[4:0];
            ALU_LSR: res = a >> b[4:0];
            ALU_ASR: res = $signed(a) >>> b[4:0];
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/iter_divider.sv
// Signed restoring divider on magnitudes, one quotient bit per iteration. The final
// iteration is combinational, so done/quotient/remainder are valid DIV_CYCLES edges after start.
module iter_divider
    import execute_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] dividend,
    input  logic signed [31:0] divisor,
    output logic               done,
    output logic        [31:0] quotient,
    output logic        [31:0] remainder
);

    localparam int            CW   = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rem_q;
    logic [31:0]   quo_q;
    logic [31:0]   dsr_q;
    logic [31:0]   dvd_q;
    logic          neg_q_q;
    logic          neg_r_q;
    logic          dz_q;

    logic [32:0]   shifted;
    logic [32:0]   diff;
    logic [31:0]   rem_step;
    logic [31:0]   quo_step;

    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dsr_q};
        rem_step = diff[32] ? shifted[31:0] : diff[31:0];
        quo_step = {quo_q[30:0], ~diff[32]};
    end

    // NOTE: the datapath registers are reset as well, so an aborted division leaves no stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= dividend[31] ? 32'(-dividend) : dividend;
            dsr_q   <= divisor[31] ? 32'(-divisor) : divisor;
            neg_q_q <= dividend[31] ^ divisor[31];
            neg_r_q <= dividend[31];
            dz_q    <= (divisor == 32'sd0);
            dvd_q   <= dividend;
        end else if (busy_q && (cnt_q != LAST)) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // done stays high with a stable result until the next start.
    assign done      = busy_q && (cnt_q == LAST);
    assign quotient  = dz_q ? 32'hFFFF_FFFF : (neg_q_q ? -quo_step : quo_step);
    assign remainder = dz_q ? dvd_q : (neg_r_q ? -rem_step : rem_step);

endmodule

// File: rtl/execute_unit.sv
// Execute stage: ALU, flag and branch resolution, EX/MA pipeline register.
// Define MULDIV_ITER_EN to run div/mod on the iterative divider; otherwise they return 0 in one cycle.
module execute_unit
    import execute_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_current,
    input  logic [31:0] branchtarget,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] immx,
    input  logic [4:0]  alusignal,
    input  logic [8:0]  ctrl,
    input  logic        ma_stall,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] aluresult,
    output logic [31:0] out_op2,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic [3:0]  out_ctrl,
    output logic        branch_taken,
    output logic [31:0] branchpc,
    output logic        flag_e,
    output logic        flag_gt
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] aluresult_q, aluresult_d;
    logic [31:0] out_op2_q, out_op2_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instruction_q, out_instruction_d;
    logic [3:0]  out_ctrl_q, out_ctrl_d;
    logic        branch_taken_q, branch_taken_d;
    logic [31:0] branchpc_q, branchpc_d;
    logic        flag_e_q, flag_e_d;
    logic        flag_gt_q, flag_gt_d;

    logic [31:0] b_operand;
    logic        take_branch;

    assign b_operand   = ctrl[CTRL_IMM] ? immx : op2;
    assign take_branch = ctrl[CTRL_UBRANCH] | (ctrl[CTRL_BEQ] & flag_e_q) | (ctrl[CTRL_BGT] & flag_gt_q);

`ifdef MULDIV_ITER_EN
    typedef enum logic {ST_IDLE, ST_DIV} state_e;

    state_e      state_q, state_d;
    logic        is_mod_q, is_mod_d;
    logic        pend_taken_q, pend_taken_d;
    logic        is_divmod;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    assign is_divmod = (alusignal == ALU_DIV) || (alusignal == ALU_MOD);
    assign in_ready  = !ma_stall && (state_q == ST_IDLE);
    assign div_start = in_valid && in_ready && is_divmod;

    iter_divider #(.DIV_CYCLES(DIV_CYCLES)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (op1),
        .divisor   (b_operand),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            is_mod_q     <= 1'b0;
            pend_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_mod_q     <= is_mod_d;
            pend_taken_q <= pend_taken_d;
        end
    end
`else
    localparam int unused_div_cycles = DIV_CYCLES;

    assign in_ready = !ma_stall;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        out_valid_d       = out_valid_q;
        aluresult_d       = aluresult_q;
        out_op2_d         = out_op2_q;
        out_pc_d          = out_pc_q;
        out_instruction_d = out_instruction_q;
        out_ctrl_d        = out_ctrl_q;
        branch_taken_d    = branch_taken_q;
        branchpc_d        = branchpc_q;
        flag_e_d          = flag_e_q;
        flag_gt_d         = flag_gt_q;
`ifdef MULDIV_ITER_EN
        state_d           = state_q;
        is_mod_d          = is_mod_q;
        pend_taken_d      = pend_taken_q;
`endif
        if (in_ready) begin
            out_valid_d    = 1'b0;
            branch_taken_d = 1'b0;
            if (in_valid) begin
                out_valid_d       = 1'b1;
                aluresult_d       = alu_compute(alusignal, op1, b_operand);
                branch_taken_d    = take_branch;
                out_op2_d         = op2;
                out_pc_d          = pc_current;
                out_instruction_d = instruction;
                out_ctrl_d        = {ctrl[CTRL_ST], ctrl[CTRL_LD], ctrl[CTRL_WB], ctrl[CTRL_CALL]};
                branchpc_d        = ctrl[CTRL_RET] ? op1 : branchtarget;
                if (alusignal == ALU_CMP) begin
                    flag_e_d  = (op1 == b_operand);
                    flag_gt_d = $signed(op1) > $signed(b_operand);
                end
`ifdef MULDIV_ITER_EN
                // Result and redirect are withheld until the divider finishes.
                if (is_divmod) begin
                    out_valid_d    = 1'b0;
                    branch_taken_d = 1'b0;
                    aluresult_d    = aluresult_q;
                    pend_taken_d   = take_branch;
                    is_mod_d       = (alusignal == ALU_MOD);
                    state_d        = ST_DIV;
                end
`endif
            end
        end
`ifdef MULDIV_ITER_EN
        if ((state_q == ST_DIV) && div_done && !ma_stall) begin
            out_valid_d    = 1'b1;
            aluresult_d    = is_mod_q ? div_remainder : div_quotient;
            branch_taken_d = pend_taken_q;
            state_d        = ST_IDLE;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q       <= 1'b0;
            aluresult_q       <= '0;
            out_op2_q         <= '0;
            out_pc_q          <= '0;
            out_instruction_q <= '0;
            out_ctrl_q        <= '0;
            branch_taken_q    <= 1'b0;
            branchpc_q        <= '0;
            flag_e_q          <= 1'b0;
            flag_gt_q         <= 1'b0;
        end else begin
            out_valid_q       <= out_valid_d;
            aluresult_q       <= aluresult_d;
            out_op2_q         <= out_op2_d;
            out_pc_q          <= out_pc_d;
            out_instruction_q <= out_instruction_d;
            out_ctrl_q        <= out_ctrl_d;
            branch_taken_q    <= branch_taken_d;
            branchpc_q        <= branchpc_d;
            flag_e_q          <= flag_e_d;
            flag_gt_q         <= flag_gt_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign aluresult       = aluresult_q;
    assign out_op2         = out_op2_q;
    assign out_pc          = out_pc_q;
    assign out_instruction = out_instruction_q;
    assign out_ctrl        = out_ctrl_q;
    assign branch_taken    = branch_taken_q;
    assign branchpc        = branchpc_q;
    assign flag_e          = flag_e_q;
    assign flag_gt         = flag_gt_q;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed cases plus randomized traffic
// against a behavioural model. Honours MULDIV_ITER_EN the same way the design does.
module tb_execute_unit;

    localparam int DIV_CYCLES = 32;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11;
    localparam logic [4:0] OP_ASR = 5'd12;

    localparam logic [8:0] C_ST  = 9'h100, C_LD  = 9'h080, C_BEQ = 9'h040, C_BGT  = 9'h020;
    localparam logic [8:0] C_RET = 9'h010, C_IMM = 9'h008, C_WB  = 9'h004, C_UB   = 9'h002;
    localparam logic [8:0] C_CALL = 9'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] pc_current = '0;
    logic [31:0] branchtarget = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] immx = '0;
    logic [4:0]  alusignal = '0;
    logic [8:0]  ctrl = '0;
    logic        ma_stall = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] aluresult;
    logic [31:0] out_op2;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [3:0]  out_ctrl;
    logic        branch_taken;
    logic [31:0] branchpc;
    logic        flag_e;
    logic        flag_gt;

    always #5 clk = ~clk;

    execute_unit #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .instruction     (instruction),
        .pc_current      (pc_current),
        .branchtarget    (branchtarget),
        .op1             (op1),
        .op2             (op2),
        .immx            (immx),
        .alusignal       (alusignal),
        .ctrl            (ctrl),
        .ma_stall        (ma_stall),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .aluresult       (aluresult),
        .out_op2         (out_op2),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_ctrl        (out_ctrl),
        .branch_taken    (branch_taken),
        .branchpc        (branchpc),
        .flag_e          (flag_e),
        .flag_gt         (flag_gt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the EX/MA register should hold.
    logic        m_valid, m_taken, m_fe, m_fgt;
    logic [31:0] m_result, m_op2, m_pc, m_instr, m_bpc;
    logic [3:0]  m_ctrl4;
    int          m_div_left;
    logic [31:0] m_div_res;
    logic        m_div_taken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p[31:0];
            end
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_NOT: return ~b;
            OP_MOV: return b;
            OP_LSL: return a << b[4:0];
            OP_LSR: return a >> b[4:0];
            OP_ASR: return $signed(a) >>> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic is_mod);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'h0) return is_mod ? a : 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_mod ? 32'h0 : 32'h8000_0000;
        return is_mod ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic logic exp_ready();
        return !ma_stall && (m_div_left == 0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_fe = 0; m_fgt = 0;
        m_result = '0; m_op2 = '0; m_pc = '0; m_instr = '0; m_bpc = '0; m_ctrl4 = '0;
        m_div_left = 0; m_div_res = '0; m_div_taken = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] b;
        logic        taken;
        if (m_div_left > 0) begin
            if (m_div_left > 1) m_div_left--;
            else if (!ma_stall) begin
                m_valid = 1; m_result = m_div_res; m_taken = m_div_taken; m_div_left = 0;
            end
        end else if (!ma_stall) begin
            m_valid = 0;
            m_taken = 0;
            if (in_valid) begin
                b       = ctrl[3] ? immx : op2;
                taken   = ctrl[1] | (ctrl[6] & m_fe) | (ctrl[5] & m_fgt);
                m_pc    = pc_current;
                m_instr = instruction;
                m_op2   = op2;
                m_ctrl4 = {ctrl[8], ctrl[7], ctrl[2], ctrl[0]};
                m_bpc   = ctrl[4] ? op1 : branchtarget;
                if (alusignal == OP_CMP) begin
                    m_fe  = (op1 == b);
                    m_fgt = $signed(op1) > $signed(b);
                end
`ifdef MULDIV_ITER_EN
                if (alusignal == OP_DIV || alusignal == OP_MOD) begin
                    m_div_left  = DIV_CYCLES;
                    m_div_res   = ref_div(op1, b, alusignal == OP_MOD);
                    m_div_taken = taken;
                end else begin
                    m_valid = 1; m_result = ref_alu(alusignal, op1, b); m_taken = taken;
                end
`else
                m_valid = 1; m_result = ref_alu(alusignal, op1, b); m_taken = taken;
`endif
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("branch_taken", branch_taken, m_taken);
        check("flag_e", flag_e, m_fe);
        check("flag_gt", flag_gt, m_fgt);
        check("aluresult", aluresult, m_result);
        check("out_op2", out_op2, m_op2);
        check("out_pc", out_pc, m_pc);
        check("out_instruction", out_instruction, m_instr);
        check("out_ctrl", out_ctrl, m_ctrl4);
        check("branchpc", branchpc, m_bpc);
    endtask

    task automatic cycle();
        #1;
        check("in_ready", in_ready, exp_ready());
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [8:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] bt, input logic stall);
        in_valid     = v;
        alusignal    = op;
        ctrl         = c;
        op1          = a;
        op2          = b;
        immx         = imm;
        branchtarget = bt;
        ma_stall     = stall;
        instruction  = $urandom;
        pc_current   = $urandom;
    endtask

    // Asserts rst between clock edges and checks the outputs clear without waiting for a clock.
    task automatic apply_reset();
        #2;
        in_valid = 0;
        ma_stall = 0;
        rst = 1;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check_outputs();
        @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_iter, input string tag);
        int waited;
        waited = 0;
        drive(1, op, C_WB, a, b, 32'h0, 32'h0, 0);
        cycle();
        drive(0, OP_ADD, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        while (!out_valid && waited < DIV_CYCLES + 8) begin
            cycle();
            waited++;
        end
`ifdef MULDIV_ITER_EN
        check({tag, "_res"}, aluresult, exp_iter);
        check({tag, "_wait"}, waited, DIV_CYCLES);
`else
        check({tag, "_res"}, aluresult, 32'h0);
        check({tag, "_wait"}, waited, 0);
`endif
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_op();
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(13, 31));
        return 5'($urandom_range(0, 12));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        apply_reset();

        // add with immediate
        drive(1, OP_ADD, C_IMM | C_WB, 32'd5, 32'd99, 32'd7, 32'h0, 0);
        cycle();
        check("add_result", aluresult, 32'd12);
        check("add_valid", out_valid, 1'b1);

        // cmp equal, then beq taken, then bgt not taken
        drive(1, OP_CMP, 9'h0, 32'd3, 32'd3, 32'd0, 32'h0, 0);
        cycle();
        check("cmp_flag_e", flag_e, 1'b1);
        check("cmp_result", aluresult, 32'h0);
        drive(1, OP_ADD, C_BEQ, 32'd1, 32'd1, 32'd0, 32'h40, 0);
        cycle();
        check("beq_taken", branch_taken, 1'b1);
        check("beq_pc", branchpc, 32'h40);
        drive(1, OP_ADD, C_BGT, 32'd1, 32'd1, 32'd0, 32'h80, 0);
        cycle();
        check("bgt_taken", branch_taken, 1'b0);

        // ret uses op1 as the target
        drive(1, OP_MOV, C_RET | C_UB, 32'h100, 32'd0, 32'd0, 32'h44, 0);
        cycle();
        check("ret_pc", branchpc, 32'h100);
        check("ret_taken", branch_taken, 1'b1);

        // bubble
        drive(0, OP_ADD, C_UB, 32'd1, 32'd1, 32'd0, 32'h0, 0);
        cycle();
        check("bubble_valid", out_valid, 1'b0);
        check("bubble_taken", branch_taken, 1'b0);

        // ma_stall holds everything for three cycles
        drive(1, OP_ADD, C_IMM, 32'd5, 32'd0, 32'd7, 32'h0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_SUB, C_UB, 32'd100, 32'd1, 32'd0, 32'h0, 1);
            cycle();
            check("stall_hold_res", aluresult, 32'd12);
            check("stall_in_ready", in_ready, 1'b0);
        end
        drive(1, OP_SUB, 9'h0, 32'd100, 32'd1, 32'd0, 32'h0, 0);
        cycle();
        check("post_stall_res", aluresult, 32'd99);

        // division corner cases
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run_div(OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "mod_m7_2");
        run_div(OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, "div_by_0");
        run_div(OP_MOD, 32'd9, 32'd0, 32'd9, "mod_by_0");
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_div(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "mod_ovf");

        // reset in the middle of a division
        drive(1, OP_DIV, C_UB, 32'd100, 32'd7, 32'd0, 32'h0, 0);
        cycle();
        drive(0, OP_ADD, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        repeat (5) cycle();
        apply_reset();
        drive(1, OP_ADD, 9'h0, 32'd1, 32'd1, 32'd0, 32'h0, 0);
        cycle();
        check("post_rst_add", aluresult, 32'd2);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            drive($urandom_range(0, 9) != 0, rand_op(), 9'($urandom), rand_word(), rand_word(),
                  rand_word(), $urandom, $urandom_range(0, 4) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk in 1 (rising-edge), rst in 1 (asynchronous, active-high).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 32: number of iteration cycles in the divider.
REQ-003 The block SHALL have these inputs:
- in_valid in 1: OF/EX register holds a live instruction.
- instruction in 32: passed through.
- pc_current in 32: passed through.
- branchtarget in 32: PC-relative target.
- op1 in 32: ALU A, and return address for ret.
- op2 in 32: register B, and store data.
- immx in 32: extended immediate.
- alusignal in 5: ALU opcode.
- ctrl in 9: {isst,isld,isbeq,isbgt,isret,isimmediate,iswb,isubranch,iscall}.
- ma_stall in 1: downstream cannot accept.
REQ-004 The block SHALL have these outputs:
- in_ready out 1: an instruction is accepted when in_valid&&in_ready.
- out_valid out 1: EX/MA register is live.
- aluresult out 32: ALU result.
- out_op2 out 32: store data.
- out_pc out 32: passed-through PC.
- out_instruction out 32: passed-through instruction.
- out_ctrl out 4: {isst,isld,iswb,iscall}.
- branch_taken out 1: redirect request.
- branchpc out 32: redirect target.
- flag_e out 1: equal flag.
- flag_gt out 1: greater-than flag.

Function
REQ-005 B operand SHALL be immx when isimmediate=1, else op2.
REQ-006 Opcodes 0-12 SHALL map to: add, sub, mul, div, mod, cmp, and, or, not, mov, lsl, lsr, asr. Codes 13-31 SHALL yield result 0.
REQ-007 Arithmetic SHALL be 32-bit two's complement, with overflow discarded. mul SHALL return the low 32 bits of the signed product. Shifts SHALL use B[4:0]. not and mov SHALL use B only.
REQ-008 cmp SHALL update the flags at acceptance:
- flag_e <= (A==B).
- flag_gt <= signed A>B.
- aluresult SHALL be 0.
No other opcode SHALL alter the flags.
REQ-009 branch_taken SHALL be computed as isubranch | (isbeq&flag_e) | (isbgt&flag_gt), using the flags as they stood before this instruction.
REQ-010 branchpc SHALL be op1 when isret=1, else branchtarget.
REQ-011 Single-cycle ops SHALL register all outputs on the accepting edge: out_valid=1 one cycle after acceptance.
REQ-012 branch_taken SHALL be asserted only while out_valid=1. It SHALL be a one-cycle pulse per instruction.
REQ-013 in_ready SHALL equal !ma_stall && state==IDLE.
REQ-014 While ma_stall=1, all outputs SHALL hold unchanged.
REQ-015 The FSM SHALL have states IDLE and DIV:
- IDLE->DIV on acceptance of div or mod.
- DIV->IDLE after DIV_CYCLES iterations, when the result is registered with out_valid=1.
REQ-016 While in DIV, in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-017 div/mod SHALL be signed, operating on magnitudes with the sign fixed at the end:
- quotient truncates toward zero.
- remainder takes the sign of the dividend.
REQ-018 Divide by zero SHALL give quotient 32'hFFFF_FFFF and remainder A.
REQ-019 Division 32'h8000_0000 / -1 SHALL give quotient 32'h8000_0000 and remainder 0.
REQ-020 When in_valid=0 and in_ready=1, out_valid SHALL be 0 on the next edge (bubble insertion).

Reset
REQ-021 rst SHALL asynchronously clear all of: out_valid, branch_taken, flag_e, flag_gt, every data output, and the divider state. The FSM SHALL go to IDLE and in_ready SHALL return to 1.
REQ-022 rst during DIV SHALL abort the division with no output produced.

Configuration
REQ-023 With MULDIV_ITER_EN defined, div/mod SHALL use the iterative divider per REQ-015 to REQ-019.
REQ-024 Without MULDIV_ITER_EN, div and mod SHALL complete in one cycle with result 0. The DIV state SHALL be absent and in_ready SHALL equal !ma_stall.

Structure
REQ-025 Package execute_pkg SHALL hold the alusignal opcode enum, the ctrl bit-index constants, and the DIV_CYCLES default.
REQ-026 The divider SHALL be a sub-module, iter_divider, with start/done handshake, signed operands, and outputs quotient and remainder.

Verification
REQ-027 add: op1=5, immx=7, isimmediate=1 -> aluresult=12, out_valid=1 one cycle later.
REQ-028 cmp op1=3, op2=3, then beq with branchtarget=0x40 -> flag_e=1, branch_taken=1, branchpc=0x40. A following bgt -> branch_taken=0.
REQ-029 ret with op1=0x100 -> branchpc=0x100, branch_taken=1.
REQ-030 div: -7 / 2 -> in_ready=0 for 32 cycles, then quotient -3. mod: -7 mod 2 -> -1. x/0 -> 0xFFFFFFFF.
REQ-031 ma_stall=1 for 3 cycles holds all outputs, with in_ready=0. Asserting rst mid-DIV -> out_valid=0 and in_ready=1 immediately.
